// File: rtl/uart_flow_responder_if.sv
// Byte-level UART link and frame-level handshakes of the far-end flow responder.
// The slave modport is the responder; the master modport is its environment.
interface uart_flow_responder_if #(
   parameter int HEADER_SIZE  = 32,
   parameter int MESSAGE_SIZE = 512
);
   logic                    ll_rx_valid_in;
   logic [7:0]              ll_rx_byte_in;
   logic                    ll_rx_ready_out;
   logic                    frame_valid_out;
   logic                    frame_ready_in;
   logic [HEADER_SIZE-1:0]  frame_header_out;
   logic [MESSAGE_SIZE-1:0] frame_message_out;
   logic                    tx_valid_in;
   logic                    tx_ready_out;
   logic [HEADER_SIZE-1:0]  tx_header_in;
   logic [MESSAGE_SIZE-1:0] tx_message_in;
   logic                    ll_tx_valid_out;
   logic [7:0]              ll_tx_byte_out;
   logic                    ll_tx_ready_in;
   logic                    peer_stalled_out;
   logic [7:0]              ctrl_count_out;

   modport slave (
      input  ll_rx_valid_in, ll_rx_byte_in, frame_ready_in,
      input  tx_valid_in, tx_header_in, tx_message_in, ll_tx_ready_in,
      output ll_rx_ready_out, frame_valid_out,
      output frame_header_out, frame_message_out,
      output tx_ready_out, ll_tx_valid_out, ll_tx_byte_out,
      output peer_stalled_out, ctrl_count_out
   );

   modport master (
      output ll_rx_valid_in, ll_rx_byte_in, frame_ready_in,
      output tx_valid_in, tx_header_in, tx_message_in, ll_tx_ready_in,
      input  ll_rx_ready_out, frame_valid_out,
      input  frame_header_out, frame_message_out,
      input  tx_ready_out, ll_tx_valid_out, ll_tx_byte_out,
      input  peer_stalled_out, ctrl_count_out
   );
endinterface

// File: rtl/uart_flow_responder.sv
// Far-end UART frame responder: deframes rx frames, decodes STALL/UNSTALL,
// and serializes tx frames MSB-first, pausing between frames while stalled.
module uart_flow_responder #(
   parameter int MESSAGE_SIZE = 512,
   parameter int HEADER_SIZE  = 32,
   parameter logic [HEADER_SIZE-1:0] STALL_HEADER   = 32'h0000_0080,
   parameter logic [HEADER_SIZE-1:0] UNSTALL_HEADER = 32'h0000_0040
) (
   input logic clk_in,
   input logic rst_in,
   uart_flow_responder_if.slave bus
);
   localparam int FRAME_BITS  = HEADER_SIZE + MESSAGE_SIZE;
   localparam int FRAME_BYTES = FRAME_BITS / 8;
   localparam int CW          = $clog2(FRAME_BYTES);
   localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES - 1);

   typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   rx_state_t rx_state, rx_next;
   tx_state_t tx_state, tx_next;

   logic [FRAME_BITS-1:0]   rx_sr, rx_full, tx_sr;
   logic [CW-1:0]           rx_cnt, tx_cnt;
   logic [HEADER_SIZE-1:0]  rx_hdr, hdr_q;
   logic [MESSAGE_SIZE-1:0] msg_q;
   logic [7:0]              ctrl_cnt;
   logic rx_fire, rx_last, is_stall, is_unstall, is_data;
   logic tx_ready, tx_accept, tx_fire, tx_last, stalled;

   // Classification looks at the register as it will be after this byte
   assign rx_full    = {rx_sr[FRAME_BITS-9:0], bus.ll_rx_byte_in};
   assign rx_hdr     = rx_full[FRAME_BITS-1 -: HEADER_SIZE];
   assign rx_fire    = bus.ll_rx_valid_in && (rx_state == RX_COLLECT);
   assign rx_last    = rx_fire && (rx_cnt == LAST);
   assign is_stall   = rx_last && (rx_hdr == STALL_HEADER);
   assign is_unstall = rx_last && (rx_hdr == UNSTALL_HEADER);
   assign is_data    = rx_last && !is_stall && !is_unstall;

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         RX_COLLECT: if (is_data) rx_next = RX_HOLD;
         RX_HOLD:    if (bus.frame_ready_in) rx_next = RX_COLLECT;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) rx_state <= RX_COLLECT;
      else         rx_state <= rx_next;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rx_sr    <= '0;
         rx_cnt   <= '0;
         stalled  <= 1'b0;
         ctrl_cnt <= 8'd0;
         hdr_q    <= '0;
         msg_q    <= '0;
      end else if (rx_fire) begin
         rx_sr  <= rx_full;
         rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
         if (is_stall || is_unstall) begin
            stalled  <= is_stall;
            ctrl_cnt <= ctrl_cnt + 8'd1;
         end
         if (is_data) begin
            hdr_q <= rx_hdr;
            msg_q <= rx_full[MESSAGE_SIZE-1:0];
         end
      end
   end

   assign bus.ll_rx_ready_out   = (rx_state == RX_COLLECT);
   assign bus.frame_valid_out   = (rx_state == RX_HOLD);
   assign bus.frame_header_out  = hdr_q;
   assign bus.frame_message_out = msg_q;
   assign bus.peer_stalled_out  = stalled;
   assign bus.ctrl_count_out    = ctrl_cnt;

   // Stall only gates new frames; a frame already in TX_SEND runs to completion
   assign tx_ready  = (tx_state == TX_IDLE) && !stalled;
   assign tx_accept = bus.tx_valid_in && tx_ready;
   assign tx_fire   = (tx_state == TX_SEND) && bus.ll_tx_ready_in;
   assign tx_last   = tx_fire && (tx_cnt == LAST);

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         TX_IDLE: if (tx_accept) tx_next = TX_SEND;
         TX_SEND: if (tx_last) tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) tx_state <= TX_IDLE;
      else         tx_state <= tx_next;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         tx_sr  <= '0;
         tx_cnt <= '0;
      end else if (tx_accept) begin
         tx_sr  <= {bus.tx_header_in, bus.tx_message_in};
         tx_cnt <= '0;
      end else if (tx_fire) begin
         tx_sr  <= tx_sr << 8;
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

   assign bus.tx_ready_out    = tx_ready;
   assign bus.ll_tx_valid_out = (tx_state == TX_SEND);
   assign bus.ll_tx_byte_out  = tx_sr[FRAME_BITS-1 -: 8];
endmodule
